traffic_phase_ctrl: RTL and testbench
=====================================

# traffic_phase_ctrl

Parametrised four-way intersection phase controller: the next generation of the team's fixed-schedule traffic state machine. It runs on the 1 Hz tick domain. It sequences NS/EW through green, yellow and all-red clearance, with optional protected left-turn phases and latched pedestrian walk countdowns. It adds emergency preemption and a night-flash mode, and all phase durations are parameters. Its outputs drive LEDs, two 7-segment pedestrian digits and the beeper directly.

## Interface
- `GREEN_T`, 12: green duration in ticks (≥ `PED_T`+1)
- `YELLOW_T`, 3: yellow duration in ticks (≥1)
- `ALLRED_T`, 1: all-red clearance duration in ticks (≥1)
- `LT_T`, 5: protected left-turn duration in ticks (≥1)
- `PED_T`, 10: walk countdown length in ticks (1..10)
- `CLK1HZ`  in  1  phase clock (1 Hz tick)
- `reset`  in  1  asynchronous, active-high
- `nslt_en`, `ewlt_en`  in  1 each  enable the NS / EW left-turn phase
- `ns_ped_btn`, `ew_ped_btn`  in  1 each  pedestrian buttons (level, sampled each tick)
- `preempt_ns`  in  1  emergency preemption: force and hold NS green
- `flash_mode`  in  1  night flash request
- `ns_led`, `ew_led`  out  3 each  one-hot {R,Y,G}: 100 red, 010 yellow, 001 green, 000 dark
- `nslt_led`, `ewlt_led`  out  1 each  left-turn arrows
- `ns_count`, `ew_count`  out  4 each  walk digit 9..0; 15 = blank
- `beep`  out  1  walk audible
- `ns_ped_req`, `ew_ped_req`  out  1 each  latched pedestrian requests
- `phase`  out  4  current state encoding, for debug

## Operation
- States: NS_GREEN, NS_YELLOW, AR_NS2EW, EWLT, EW_GREEN, EW_YELLOW, AR_EW2NS, NSLT, FLASH.
- A single down-counter `tmr` is loaded with duration−1 on every state entry. The state exits when `tmr`==0.
- Normal cycle: NS_GREEN → NS_YELLOW → AR_NS2EW → (EWLT if `ewlt_en`, else EW_GREEN).
  - EWLT → EW_GREEN.
  - EW_GREEN → EW_YELLOW → AR_EW2NS → (NSLT if `nslt_en`, else NS_GREEN).
  - NSLT → NS_GREEN.
- `*lt_en` is sampled only at the AR exit tick.
- LEDs per state:
  - Greens and yellows show the named colour on that approach and red on the other.
  - AR, EWLT and NSLT show both approaches red.
  - EWLT sets `ewlt_led`=1. NSLT sets `nslt_led`=1.
- Pedestrian requests:
  - A button high at any tick sets the corresponding `*_ped_req`.
  - At entry to that direction's green, `walk` = `req` is captured.
  - If `walk` is set, the count shows `PED_T`−1 down to 0, one step per tick, then holds 0 until green exits. `beep`=1 while the displayed count is >0 or equal to 0 on its first tick.
  - On the exit tick of a walked green, `req` is cleared. A button press on that same tick wins, and `req` stays set.
  - A request raised mid-green is not served until the next green of that direction.
  - Outside a walked green, the count shows 15.
- Preemption (`preempt_ns`=1):
  - In NS_GREEN: the timer freezes and the state holds.
  - In NS_YELLOW or AR_NS2EW: these complete normally, then the controller jumps to AR_EW2NS instead of proceeding.
  - In EWLT or EW_GREEN: the controller goes to EW_YELLOW next tick.
  - In EW_YELLOW or AR_EW2NS: these complete normally.
  - Left turns are skipped while preempt is asserted.
  - When preempt is released in NS_GREEN, the timer reloads `GREEN_T`−1.
- Flash (`flash_mode`=1, lower priority than preempt):
  - The controller enters FLASH at the next AR exit.
  - In FLASH, `ns_led` alternates 010/000 and `ew_led` alternates 100/000 each tick, starting lit.
  - When flash deasserts, the controller goes to AR_EW2NS and then NS_GREEN.
  - Ped requests still latch during FLASH but are not served in it.

## Timing
- All state, timer, request and walk flags are registered on `CLK1HZ`. Outputs are combinational from those registers.
- Reset values:
  - phase=NS_GREEN, `tmr`=`GREEN_T`−1, `ns_led`=001, `ew_led`=100
  - `*lt_led`=0, `ns_count`=`ew_count`=15, `beep`=0, `*_ped_req`=0, walk=0
  - The first NS green after reset is not walked.
- State durations are exactly the parameter value in ticks. Full cycle = 2·(`GREEN_T`+`YELLOW_T`+`ALLRED_T`) + optional `LT_T` per enabled turn.
- Reset asserted mid-phase: immediate return to the reset values, with no clearance interval.
- `tmr` width: $clog2 of the max duration, plus 1.

## Structure
- Package `traffic_pkg`:
  - state enum
  - LED colour constants RED/YELLOW/GREEN/DARK
  - BLANK=4'd15
- Sub-module `ped_walk_ctr`, one per direction: request latch, walk capture, countdown, and `beep` contribution. Top-level `beep` = OR of both.

## Test plan
- Defaults, no inputs: NS_GREEN for 12 ticks, yellow 3, AR 1, EW_GREEN 12, yellow 3, AR 1; 32-tick period; counts stay 15.
- `ns_ped_btn` pulsed during EW_GREEN: next NS green `ns_count` shows 9..0 over ticks 0–9, holds 0 for ticks 10–11; `beep`=1 on ticks 0–9; `ns_ped_req` clears at NS_GREEN exit.
- `ewlt_en`=1, `nslt_en`=1: EWLT with `ewlt_led`=1 lasts 5 ticks between AR_NS2EW and EW_GREEN, and NSLT likewise before NS_GREEN; period 42.
- `preempt_ns` raised at EW_GREEN tick 4: EW_YELLOW 3 → AR 1 → NS_GREEN held for 20 ticks; on release, NS green lasts 12 more ticks.
- `flash_mode` set during NS_GREEN: FLASH entered after AR_NS2EW; `ns_led` toggles 010/000 and `ew_led` 100/000; on deassert, AR 1 then NS_GREEN.
- Reset asserted mid-EW_YELLOW with `ew_ped_req`=1: all outputs return to reset values asynchronously; `ew_ped_req`=0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and constants for the four-way intersection phase controller.
package traffic_pkg;

  // Controller phases; the encoding is also exported on the debug `phase` port.
  typedef enum logic [3:0] {
    NS_GREEN  = 4'd0,
    NS_YELLOW = 4'd1,
    AR_NS2EW  = 4'd2,
    EWLT      = 4'd3,
    EW_GREEN  = 4'd4,
    EW_YELLOW = 4'd5,
    AR_EW2NS  = 4'd6,
    NSLT      = 4'd7,
    FLASH     = 4'd8
  } state_t;

  // One-hot {R,Y,G} lamp patterns.
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] DARK   = 3'b000;

  // Digit code that blanks the pedestrian 7-segment display.
  localparam logic [3:0] BLANK = 4'd15;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_ped_walk_ctr.sv
// Per-direction pedestrian logic: request latch, walk capture at green entry,
// walk countdown digit and beeper contribution.
module ped_walk_ctr
  import traffic_pkg::*;
#(
  parameter int PED_T = 10
) (
  input  logic       CLK1HZ,
  input  logic       reset,
  input  logic       btn_i,
  input  logic       green_entry_i,
  input  logic       green_exit_i,
  output logic       req_o,
  output logic [3:0] count_o,
  output logic       beep_o
);

  logic       req_q, req_d;
  logic       walk_q, walk_d;
  // Remaining audible ticks, PED_T down to 0; the shown digit is one less,
  // floored at 0, so the first tick at 0 still beeps.
  logic [3:0] cnt_q, cnt_d;

  // Next-state for request, walk flag and countdown.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    req_d  = req_q;
    walk_d = walk_q;
    cnt_d  = cnt_q;
    if (green_entry_i) begin
      walk_d = req_q;
      cnt_d  = 4'(PED_T);
    end else if (green_exit_i) begin
      walk_d = 1'b0;
      cnt_d  = '0;
      if (walk_q) req_d = 1'b0;
    end else if (walk_q && (cnt_q != '0)) begin
      cnt_d = cnt_q - 4'd1;
    end
    // A press on the clearing tick keeps the request alive.
    if (btn_i) req_d = 1'b1;
  end

  // Registers with asynchronous active-high reset.
  always_ff @(posedge CLK1HZ or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      req_q  <= 1'b0;
      walk_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      req_q  <= req_d;
      walk_q <= walk_d;
      cnt_q  <= cnt_d;
    end
  end

  // Display digit and beeper from the registered walk state.
  always_comb begin
    req_o   = req_q;
    beep_o  = walk_q && (cnt_q != '0);
    count_o = BLANK;
    if (walk_q) count_o = (cnt_q == '0) ? 4'd0 : (cnt_q - 4'd1);
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Four-way intersection phase controller: green/yellow/all-red sequencing,
// optional protected left turns, pedestrian walks, NS emergency preemption
// and night flash. Runs on the 1 Hz tick.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_T  = 12,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 1,
  parameter int LT_T     = 5,
  parameter int PED_T    = 10
) (
  input  logic       CLK1HZ,
  input  logic       reset,
  input  logic       nslt_en,
  input  logic       ewlt_en,
  input  logic       ns_ped_btn,
  input  logic       ew_ped_btn,
  input  logic       preempt_ns,
  input  logic       flash_mode,
  output logic [2:0] ns_led,
  output logic [2:0] ew_led,
  output logic       nslt_led,
  output logic       ewlt_led,
  output logic [3:0] ns_count,
  output logic [3:0] ew_count,
  output logic       beep,
  output logic       ns_ped_req,
  output logic       ew_ped_req,
  output logic [3:0] phase
);

  localparam int MAX_T = max_of(max_of(GREEN_T, YELLOW_T), max_of(ALLRED_T, LT_T));
  localparam int TW    = $clog2(MAX_T) + 1;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            blink_q, blink_d;
  logic            expired;
  logic            ns_beep, ew_beep;

  // Timer load value (duration - 1) for the phase being entered.
  function automatic logic [TW-1:0] load_for(input state_t s);
    case (s)
      NS_GREEN, EW_GREEN:   return TW'(GREEN_T - 1);
      NS_YELLOW, EW_YELLOW: return TW'(YELLOW_T - 1);
      AR_NS2EW, AR_EW2NS:   return TW'(ALLRED_T - 1);
      EWLT, NSLT:           return TW'(LT_T - 1);
      default:              return '0;
    endcase
  endfunction

  assign expired = (tmr_q == '0);

  // Next phase, timer and flash blink phase.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    blink_d = blink_q;
    case (state_q)
      NS_GREEN:  if (!preempt_ns && expired) state_d = NS_YELLOW;
      NS_YELLOW: if (expired) state_d = AR_NS2EW;
      AR_NS2EW:
        if (expired) begin
          if (preempt_ns)      state_d = AR_EW2NS;
          else if (flash_mode) state_d = FLASH;
          else if (ewlt_en)    state_d = EWLT;
          else                 state_d = EW_GREEN;
        end
      EWLT:
        if (preempt_ns)   state_d = EW_YELLOW;
        else if (expired) state_d = EW_GREEN;
      EW_GREEN:  if (preempt_ns || expired) state_d = EW_YELLOW;
      EW_YELLOW: if (expired) state_d = AR_EW2NS;
      AR_EW2NS:
        if (expired) begin
          if (preempt_ns)      state_d = NS_GREEN;
          else if (flash_mode) state_d = FLASH;
          else if (nslt_en)    state_d = NSLT;
          else                 state_d = NS_GREEN;
        end
      NSLT:      if (expired) state_d = NS_GREEN;
      FLASH: begin
        blink_d = ~blink_q;
        if (preempt_ns || !flash_mode) state_d = AR_EW2NS;
      end
      default:   state_d = NS_GREEN;
    endcase

    // Held NS green keeps the full green queued for when preempt drops.
    if (state_d != state_q)                      tmr_d = load_for(state_d);
    else if (state_q == NS_GREEN && preempt_ns)  tmr_d = load_for(NS_GREEN);
    else if (!expired)                           tmr_d = tmr_q - TW'(1);

    if (state_d == FLASH && state_q != FLASH) blink_d = 1'b1;
  end

  // Phase, timer and blink registers; reset lands directly in NS green.
  always_ff @(posedge CLK1HZ or posedge reset) begin
    if (reset) begin
      state_q <= NS_GREEN;
      tmr_q   <= TW'(GREEN_T - 1);
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      blink_q <= blink_d;
    end
  end

  ped_walk_ctr #(.PED_T(PED_T)) u_ns_ped (
    .CLK1HZ        (CLK1HZ),
    .reset         (reset),
    .btn_i         (ns_ped_btn),
    .green_entry_i ((state_d == NS_GREEN) && (state_q != NS_GREEN)),
    .green_exit_i  ((state_q == NS_GREEN) && (state_d != NS_GREEN)),
    .req_o         (ns_ped_req),
    .count_o       (ns_count),
    .beep_o        (ns_beep)
  );

  ped_walk_ctr #(.PED_T(PED_T)) u_ew_ped (
    .CLK1HZ        (CLK1HZ),
    .reset         (reset),
    .btn_i         (ew_ped_btn),
    .green_entry_i ((state_d == EW_GREEN) && (state_q != EW_GREEN)),
    .green_exit_i  ((state_q == EW_GREEN) && (state_d != EW_GREEN)),
    .req_o         (ew_ped_req),
    .count_o       (ew_count),
    .beep_o        (ew_beep)
  );

  assign beep  = ns_beep | ew_beep;
  assign phase = state_q;

  // Lamp drive decoded from the current phase.
  always_comb begin
    ns_led   = RED;
    ew_led   = RED;
    nslt_led = 1'b0;
    ewlt_led = 1'b0;
    case (state_q)
      NS_GREEN:  ns_led = GREEN;
      NS_YELLOW: ns_led = YELLOW;
      EW_GREEN:  ew_led = GREEN;
      EW_YELLOW: ew_led = YELLOW;
      EWLT:      ewlt_led = 1'b1;
      NSLT:      nslt_led = 1'b1;
      FLASH: begin
        ns_led = blink_q ? YELLOW : DARK;
        ew_led = blink_q ? RED : DARK;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: elapsed-time behavioural model
// compared on every falling edge, plus hand-computed literal checkpoints.
module tb_traffic_phase_ctrl;
  import traffic_pkg::*;

  localparam int GREEN_T  = 12;
  localparam int YELLOW_T = 3;
  localparam int ALLRED_T = 1;
  localparam int LT_T     = 5;
  localparam int PED_T    = 10;

  logic       CLK1HZ = 1'b0;
  logic       reset  = 1'b1;
  logic       nslt_en = 1'b0, ewlt_en = 1'b0;
  logic       ns_ped_btn = 1'b0, ew_ped_btn = 1'b0;
  logic       preempt_ns = 1'b0, flash_mode = 1'b0;
  logic [2:0] ns_led, ew_led;
  logic       nslt_led, ewlt_led;
  logic [3:0] ns_count, ew_count;
  logic       beep, ns_ped_req, ew_ped_req;
  logic [3:0] phase;

  int n_cmp = 0;
  int n_err = 0;

  traffic_phase_ctrl #(
    .GREEN_T(GREEN_T), .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T),
    .LT_T(LT_T), .PED_T(PED_T)
  ) dut (
    .CLK1HZ     (CLK1HZ),
    .reset      (reset),
    .nslt_en    (nslt_en),
    .ewlt_en    (ewlt_en),
    .ns_ped_btn (ns_ped_btn),
    .ew_ped_btn (ew_ped_btn),
    .preempt_ns (preempt_ns),
    .flash_mode (flash_mode),
    .ns_led     (ns_led),
    .ew_led     (ew_led),
    .nslt_led   (nslt_led),
    .ewlt_led   (ewlt_led),
    .ns_count   (ns_count),
    .ew_count   (ew_count),
    .beep       (beep),
    .ns_ped_req (ns_ped_req),
    .ew_ped_req (ew_ped_req),
    .phase      (phase)
  );

  always #5 CLK1HZ = ~CLK1HZ;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase plus ticks elapsed in it; per direction: request, walk, ticks into green.
  state_t m_ph   = NS_GREEN;
  int     m_el   = 0;
  bit     m_req[2]  = '{1'b0, 1'b0};
  bit     m_walk[2] = '{1'b0, 1'b0};
  int     m_age[2]  = '{0, 0};

  function automatic int dur(input state_t s);
    case (s)
      NS_GREEN, EW_GREEN:   return GREEN_T;
      NS_YELLOW, EW_YELLOW: return YELLOW_T;
      AR_NS2EW, AR_EW2NS:   return ALLRED_T;
      EWLT, NSLT:           return LT_T;
      default:              return 1 << 30;
    endcase
  endfunction

  task automatic m_reset();
    m_ph = NS_GREEN;
    m_el = 0;
    for (int k = 0; k < 2; k++) begin
      m_req[k] = 1'b0; m_walk[k] = 1'b0; m_age[k] = 0;
    end
  endtask

  task automatic m_step();
    state_t nx;
    bit     done;
    state_t g;
    bit     btn, entering, leaving;
    nx   = m_ph;
    done = (m_el >= dur(m_ph) - 1);
    case (m_ph)
      NS_GREEN:  if (!preempt_ns && done) nx = NS_YELLOW;
      NS_YELLOW: if (done) nx = AR_NS2EW;
      AR_NS2EW:  if (done) nx = preempt_ns ? AR_EW2NS : flash_mode ? FLASH : ewlt_en ? EWLT : EW_GREEN;
      EWLT:      if (preempt_ns) nx = EW_YELLOW; else if (done) nx = EW_GREEN;
      EW_GREEN:  if (preempt_ns || done) nx = EW_YELLOW;
      EW_YELLOW: if (done) nx = AR_EW2NS;
      AR_EW2NS:  if (done) nx = preempt_ns ? NS_GREEN : flash_mode ? FLASH : nslt_en ? NSLT : NS_GREEN;
      NSLT:      if (done) nx = NS_GREEN;
      FLASH:     if (preempt_ns || !flash_mode) nx = AR_EW2NS;
      default:   nx = NS_GREEN;
    endcase
    for (int k = 0; k < 2; k++) begin
      g        = (k == 0) ? NS_GREEN : EW_GREEN;
      btn      = (k == 0) ? ns_ped_btn : ew_ped_btn;
      entering = (nx == g) && (m_ph != g);
      leaving  = (m_ph == g) && (nx != g);
      if (entering) begin
        m_walk[k] = m_req[k];
        m_age[k]  = 0;
      end else if (leaving) begin
        if (m_walk[k]) m_req[k] = 1'b0;
        m_walk[k] = 1'b0;
      end else if (m_ph == g) begin
        m_age[k]++;
      end
      if (btn) m_req[k] = 1'b1;
    end
    if (nx != m_ph) m_el = 0;
    else if (m_ph == NS_GREEN && preempt_ns) m_el = 0;
    else m_el++;
    m_ph = nx;
  endtask

  always @(posedge CLK1HZ or posedge reset) begin
    if (reset) m_reset();
    else       m_step();
  end

  function automatic int exp_count(input int k);
    int v;
    if (!m_walk[k]) return 15;
    v = PED_T - 1 - m_age[k];
    return (v > 0) ? v : 0;
  endfunction

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge CLK1HZ) begin
    logic [2:0] e_ns, e_ew;
    logic       lit;
    e_ns = RED;
    e_ew = RED;
    lit  = (m_el % 2) == 0;
    case (m_ph)
      NS_GREEN:  e_ns = GREEN;
      NS_YELLOW: e_ns = YELLOW;
      EW_GREEN:  e_ew = GREEN;
      EW_YELLOW: e_ew = YELLOW;
      FLASH: begin
        e_ns = lit ? YELLOW : DARK;
        e_ew = lit ? RED : DARK;
      end
      default: ;
    endcase
    check("m_phase",    32'(phase),      32'(m_ph));
    check("m_ns_led",   32'(ns_led),     32'(e_ns));
    check("m_ew_led",   32'(ew_led),     32'(e_ew));
    check("m_nslt_led", 32'(nslt_led),   32'(m_ph == NSLT));
    check("m_ewlt_led", 32'(ewlt_led),   32'(m_ph == EWLT));
    check("m_ns_count", 32'(ns_count),   32'(exp_count(0)));
    check("m_ew_count", 32'(ew_count),   32'(exp_count(1)));
    check("m_beep",     32'(beep),
          32'((m_walk[0] && m_age[0] < PED_T) || (m_walk[1] && m_age[1] < PED_T)));
    check("m_ns_req",   32'(ns_ped_req), 32'(m_req[0]));
    check("m_ew_req",   32'(ew_ped_req), 32'(m_req[1]));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge CLK1HZ);
  endtask

  task automatic lit_state(input string tag, input state_t ph, input logic [2:0] ns, input logic [2:0] ew);
    check({tag, "_phase"},  32'(phase),  32'(ph));
    check({tag, "_ns_led"}, 32'(ns_led), 32'(ns));
    check({tag, "_ew_led"}, 32'(ew_led), 32'(ew));
  endtask

  initial begin
    @(negedge CLK1HZ);
    reset = 1'b0;
    // Reset values.
    lit_state("rst", NS_GREEN, 3'b001, 3'b100);
    check("rst_ns_count", 32'(ns_count), 15);
    check("rst_beep", 32'(beep), 0);

    // Default cycle; NS button pulsed in EW green.
    tick(12); lit_state("c1_nsy", NS_YELLOW, 3'b010, 3'b100);
    tick(3);  lit_state("c1_ar",  AR_NS2EW, 3'b100, 3'b100);
    tick(1);  lit_state("c1_ewg", EW_GREEN, 3'b100, 3'b001);
    tick(2);  ns_ped_btn = 1'b1;
    tick(1);  ns_ped_btn = 1'b0;
    check("btn_ns_req", 32'(ns_ped_req), 1);
    tick(9);  lit_state("c1_ewy", EW_YELLOW, 3'b100, 3'b010);
    tick(3);  lit_state("c1_ar2", AR_EW2NS, 3'b100, 3'b100);
    tick(1);  lit_state("c1_nsg", NS_GREEN, 3'b001, 3'b100);
    check("walk_t0_count", 32'(ns_count), 9);
    check("walk_t0_beep", 32'(beep), 1);
    tick(9);  check("walk_t9_count", 32'(ns_count), 0);
    check("walk_t9_beep", 32'(beep), 1);
    tick(1);  check("walk_t10_count", 32'(ns_count), 0);
    check("walk_t10_beep", 32'(beep), 0);
    tick(1);  check("walk_t11_req", 32'(ns_ped_req), 1);
    tick(1);  lit_state("walk_exit", NS_YELLOW, 3'b010, 3'b100);
    check("walk_exit_req", 32'(ns_ped_req), 0);
    check("walk_exit_count", 32'(ns_count), 15);

    // Both left turns enabled.
    nslt_en = 1'b1; ewlt_en = 1'b1;
    tick(3);
    tick(1);  lit_state("lt_ewlt", EWLT, 3'b100, 3'b100);
    check("lt_ewlt_led", 32'(ewlt_led), 1);
    tick(5);  lit_state("lt_ewg", EW_GREEN, 3'b100, 3'b001);
    tick(16); lit_state("lt_nslt", NSLT, 3'b100, 3'b100);
    check("lt_nslt_led", 32'(nslt_led), 1);
    tick(5);  lit_state("lt_nsg", NS_GREEN, 3'b001, 3'b100);
    nslt_en = 1'b0; ewlt_en = 1'b0;

    // Preempt raised at EW green tick 4.
    tick(16); lit_state("pre_ewg", EW_GREEN, 3'b100, 3'b001);
    tick(4);  preempt_ns = 1'b1;
    tick(1);  lit_state("pre_ewy", EW_YELLOW, 3'b100, 3'b010);
    tick(3);  lit_state("pre_ar", AR_EW2NS, 3'b100, 3'b100);
    tick(1);  lit_state("pre_nsg", NS_GREEN, 3'b001, 3'b100);
    tick(20); lit_state("pre_hold", NS_GREEN, 3'b001, 3'b100);
    preempt_ns = 1'b0;
    tick(11); lit_state("pre_rel11", NS_GREEN, 3'b001, 3'b100);
    tick(1);  lit_state("pre_rel12", NS_YELLOW, 3'b010, 3'b100);

    // Preempt during NS yellow: completes, then jumps to AR_EW2NS.
    preempt_ns = 1'b1;
    tick(3);  lit_state("pre2_ar", AR_NS2EW, 3'b100, 3'b100);
    tick(1);  lit_state("pre2_jump", AR_EW2NS, 3'b100, 3'b100);
    tick(1);  lit_state("pre2_nsg", NS_GREEN, 3'b001, 3'b100);
    preempt_ns = 1'b0;
    tick(12); lit_state("pre2_nsy", NS_YELLOW, 3'b010, 3'b100);

    // Night flash.
    flash_mode = 1'b1;
    tick(3);
    tick(1);  lit_state("fl_on", FLASH, 3'b010, 3'b100);
    tick(1);  lit_state("fl_off", FLASH, 3'b000, 3'b000);
    ew_ped_btn = 1'b1;
    tick(1);  lit_state("fl_on2", FLASH, 3'b010, 3'b100);
    ew_ped_btn = 1'b0;
    check("fl_ew_req", 32'(ew_ped_req), 1);
    check("fl_ew_count", 32'(ew_count), 15);
    tick(2);
    flash_mode = 1'b0;
    tick(1);  lit_state("fl_ar", AR_EW2NS, 3'b100, 3'b100);
    tick(1);  lit_state("fl_nsg", NS_GREEN, 3'b001, 3'b100);
    tick(16); lit_state("fl_ewg", EW_GREEN, 3'b100, 3'b001);
    check("fl_ew_walk", 32'(ew_count), 9);
    tick(12); lit_state("fl_ewy", EW_YELLOW, 3'b100, 3'b010);
    check("fl_ew_req_clr", 32'(ew_ped_req), 0);

    // Reset mid EW yellow with a pending EW request.
    tick(1);  ew_ped_btn = 1'b1;
    tick(1);  ew_ped_btn = 1'b0;
    check("r2_req_set", 32'(ew_ped_req), 1);
    #2 reset = 1'b1;
    #1;
    lit_state("r2", NS_GREEN, 3'b001, 3'b100);
    check("r2_ew_req", 32'(ew_ped_req), 0);
    check("r2_ew_count", 32'(ew_count), 15);
    check("r2_lt", 32'({nslt_led, ewlt_led}), 0);
    @(negedge CLK1HZ);
    reset = 1'b0;
    tick(16); lit_state("r2_ewg", EW_GREEN, 3'b100, 3'b001);
    tick(16); lit_state("r2_nsg", NS_GREEN, 3'b001, 3'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
